// File: rtl/tetris_key_input.sv
// Button conditioner for the Tetris game logic: synchronises and debounces
// four raw buttons and turns presses into one-cycle move requests, with
// delayed auto-repeat on left, right and soft-drop.

module tetris_key_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned DAS_DELAY       = 8000000,
    parameter int unsigned DAS_PERIOD      = 2000000,
    parameter int unsigned CNT_W           = 24,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,         // synchronised button level
    input  logic enable,
    input  logic conflict,  // both lateral directions held
    output logic d,         // debounced level
    output logic pulse      // registered request pulse
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKED} state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(DAS_PERIOD - 1);

    state_t           st, st_n;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] das_cnt, das_n;
    logic             clat, clat_n;   // locked only because of a lateral conflict
    logic             pulse_n;

    // Debouncer: accept a new level after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d      <= 1'b0;
            db_cnt <= '0;
        end else if (s == d) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            d      <= s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Request FSM next-state, DAS counter and pulse
    always_comb begin
        st_n    = st;
        das_n   = das_cnt;
        clat_n  = clat;
        pulse_n = 1'b0;
        if (!enable) begin
            // a held button must be released before it can fire again
            st_n   = d ? LOCKED : IDLE;
            das_n  = '0;
            clat_n = 1'b0;
        end else if (!d) begin
            st_n   = IDLE;
            das_n  = '0;
            clat_n = 1'b0;
        end else if (conflict) begin
            st_n   = LOCKED;
            das_n  = '0;
            clat_n = clat | (st != LOCKED);
        end else begin
            case (st)
                IDLE: begin
                    pulse_n = 1'b1;
                    das_n   = '0;
                    st_n    = REPEAT_EN ? DELAY : LOCKED;
                end
                DELAY: begin
                    if (das_cnt == DLY_LAST) begin
                        pulse_n = 1'b1;
                        das_n   = '0;
                        st_n    = REPEAT;
                    end else if (das_cnt < DLY_LAST) begin
                        das_n = das_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (das_cnt == PER_LAST) begin
                        pulse_n = 1'b1;
                        das_n   = '0;
                    end else if (das_cnt < PER_LAST) begin
                        das_n = das_cnt + 1'b1;
                    end
                end
                default: begin
                    // conflict just cleared with this direction still held: fresh press
                    if (clat) begin
                        pulse_n = 1'b1;
                        das_n   = '0;
                        clat_n  = 1'b0;
                        st_n    = DELAY;
                    end
                end
            endcase
        end
    end

    // FSM state, DAS counter and output pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            das_cnt <= '0;
            clat    <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            st      <= st_n;
            das_cnt <= das_n;
            clat    <= clat_n;
            pulse   <= pulse_n;
        end
    end
endmodule

module tetris_key_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned DAS_DELAY       = 8000000,
    parameter int unsigned DAS_PERIOD      = 2000000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_rotate,
    input  logic btn_down,
    input  logic enable,
    output logic move_left,
    output logic move_right,
    output logic rotate,
    output logic soft_drop
);
    localparam int NUM_BTN = 4;  // 0 left, 1 right, 2 rotate, 3 down

    logic [NUM_BTN-1:0] btn, sync1, sync2, d, pulse;
    logic               lr_conflict;

    assign btn         = {btn_down, btn_rotate, btn_right, btn_left};
    assign lr_conflict = d[0] & d[1];

    // Two-flop synchronisers for the raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        tetris_key_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DAS_DELAY      (DAS_DELAY),
            .DAS_PERIOD     (DAS_PERIOD),
            .CNT_W          (CNT_W),
            .REPEAT_EN      (i != 2)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s       (sync2[i]),
            .enable  (enable),
            .conflict((i < 2) ? lr_conflict : 1'b0),
            .d       (d[i]),
            .pulse   (pulse[i])
        );
    end

    assign move_left  = pulse[0];
    assign move_right = pulse[1];
    assign rotate     = pulse[2];
    assign soft_drop  = pulse[3];
endmodule

// File: doc/tetris_key_input.md
# tetris_key_input

Input conditioner that produces the single-cycle move requests consumed by the Tetris move/rotate/drop logic. Synchronises and debounces four raw push-buttons, converts presses into one-cycle request pulses, and applies delayed auto-repeat (DAS) to left, right and soft-drop. Sits between the board buttons and the game-state logic; its outputs feed `move_left`/`move_right` of the move stage and the rotate and drop stages.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable synchronised samples required to accept a level change; must be ≥ 1.
- `DAS_DELAY`, default 8000000: cycles from the initial pulse to the first repeat pulse.
- `DAS_PERIOD`, default 2000000: cycles between subsequent repeat pulses.
- `CNT_W`, default 24: width of the debounce and DAS counters; must hold the largest of the three values above.

- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_left`, `btn_right`, `btn_rotate`, `btn_down` input 1 each: raw, asynchronous, active-high buttons.
- `enable` input 1: high while a piece is in play; low suppresses all requests.
- `move_left`, `move_right`, `rotate`, `soft_drop` output 1 each: registered one-cycle request pulses.

## Operation
- **Synchroniser:** each button passes through its own 2-flop synchroniser, giving `s_x`.
- **Debouncer:** one per button, holding debounced level `d_x` and counter `c_x`.
  - If `s_x == d_x`, then `c_x <= 0`.
  - Otherwise `c_x` increments. On the cycle where `c_x == DEBOUNCE_CYCLES-1`: `d_x <= s_x` and `c_x <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples never changes `d_x`.
- **Request FSM:** one per button, with states IDLE, DELAY, REPEAT and LOCKED, plus a DAS counter.
  - IDLE → DELAY on rising `d_x` while `enable=1`. The initial pulse is emitted the next cycle and the DAS counter clears.
  - DELAY: counter counts up. At `DAS_DELAY` it emits a pulse, clears, and goes to REPEAT.
  - REPEAT: at `DAS_PERIOD` it emits a pulse and clears.
  - DELAY or REPEAT → IDLE on falling `d_x`. No pulse is emitted on release.
  - Rotate has no repeat: after its initial pulse it goes directly to LOCKED until `d_x` falls.
  - LOCKED → IDLE on falling `d_x`.
- **`enable` low:** all FSMs go to LOCKED if their `d_x=1`, else IDLE. No pulses are emitted and DAS counters clear. Debouncers keep running.
- **`enable` rising:** a button already held stays LOCKED. It must be released and re-pressed to fire.
- **Left/right conflict:** while both `d_left` and `d_right` are 1, both left and right FSMs are held in LOCKED and no lateral pulses are emitted. When one is released, the still-held direction returns to IDLE and is treated as a fresh press: immediate pulse, then DAS restarts.
- **Output exclusivity:** `move_left` and `move_right` are never high in the same cycle. `rotate` and `soft_drop` are independent of each other and of lateral moves.
- **Simultaneous presses:** rising `d_left` and `d_right` in the same cycle produce no pulse; both directions lock.
- **DAS counters:** saturate at their compare value and never wrap.

## Timing
- **Reset:** all outputs 0, all `d_x`=0, all counters 0, all FSMs IDLE, synchroniser flops 0.
- **Initial press latency:** let raw rise be sampled at clock edge k.
  - `s_x` rises at edge k+1.
  - `d_x` rises at edge k+1+`DEBOUNCE_CYCLES`.
  - The pulse is high for exactly one cycle, after edge k+2+`DEBOUNCE_CYCLES`.
- **Repeat spacing:** first repeat pulse comes `DAS_DELAY` cycles after the initial pulse; following pulses come every `DAS_PERIOD` cycles.
- **Release:** takes effect `DEBOUNCE_CYCLES`+2 edges after raw falls. No pulse is emitted in or after the cycle where `d_x` falls.
- **`enable` deassertion:** suppresses any pulse scheduled in the same cycle. `enable` is sampled registered-free, with effect on the next edge.
- **Reset mid-operation:** outputs clear immediately (asynchronous). After release of `rst_n`, a held button fires only after the full debounce latency, because `d_x` restarts at 0.

## Test plan
With `DEBOUNCE_CYCLES`=4, `DAS_DELAY`=10, `DAS_PERIOD`=3, `enable`=1:

- **Single press:** `btn_left` high for 8 cycles, then low → exactly one `move_left` pulse, 6 edges after the first sampling edge. `move_right`, `rotate` and `soft_drop` stay 0.
- **Glitch rejection:** `btn_rotate` high for 3 cycles, then low → no `rotate` pulse. A 10-cycle hold → one pulse, no repeat even if held for 100 cycles.
- **Auto-repeat:** hold `btn_right` for 30 cycles after debounce → pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 from the initial pulse. Stops after release.
- **Left/right conflict:**
  - Hold `btn_left` and get its initial pulse.
  - Press `btn_right` → no lateral pulses while both are held.
  - Release `btn_left` → `move_right` pulses once after the `d_left` fall, then repeats at +10 and +13.
  - `move_left` and `move_right` are never both high at any point.
- **Enable gating:** hold `btn_down` with `enable`=0 → no `soft_drop`. Raise `enable` while still held → still no pulse. Release, then re-press → pulse.
- **Reset mid-repeat:** assert `rst_n`=0 during REPEAT → `soft_drop` is 0 at once. Release reset with the button still held → first pulse after the full debounce latency (6 edges).
